noc_run_monitor: RTL and testbench
==================================

# noc_run_monitor

Synthesizable run controller and watchdog for NoC simulations and on-chip test runs. It counts packets received at every node and tracks elapsed cycles. It watches an arbitrary activity bus (typically the topology output bus) for stalls and ends the run with a sticky status: complete, timeout or stall. It sits beside the fabric/switch array and replaces ad-hoc testbench termination logic with parametrised per-node counters and a restartable state machine.

## Interface
- NODES_NUM, 16, number of nodes; one receive-pulse input per node.
- PACKS_TO_GEN, 10, packets each node generates; EXPECTED = PACKS_TO_GEN*NODES_NUM.
- CNT_WIDTH, 32, width of every counter (per-node, total, cycle, stall).
- WATCH_WIDTH, 64, width of the watched activity bus.
- STALL_LIMIT, 10000, consecutive unchanged-bus RUN cycles that declare a stall; must be >= 1.
- TEST_TIME, 100000, RUN cycles before timeout; must be >= 1.
- IDX_W, $clog2(NODES_NUM) (min 1), width of the readback index.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- a_rst  in  1  reset, asynchronous assert, active-low (0 = reset); synchronous release is the integrator's duty.
- start_i  in  1  clear all counters and (re)enter RUN; accepted in any state.
- recv_pulse_i  in  NODES_NUM  bit n high for one cycle = one packet received at node n.
- watch_i  in  WATCH_WIDTH  activity bus compared cycle to cycle.
- rd_node_i  in  IDX_W  node index for count readback.
- state_o  out  3  0 IDLE, 1 RUN, 2 COMPLETE, 3 TIMEOUT, 4 STALL.
- done_o  out  1  high in COMPLETE, TIMEOUT or STALL.
- total_o  out  CNT_WIDTH  total packets received this run.
- cycles_o  out  CNT_WIDTH  RUN cycles elapsed this run.
- rd_count_o  out  CNT_WIDTH  per-node count of node rd_node_i. Combinational mux of registers. Index >= NODES_NUM returns 0.

## Operation
- Reset: state IDLE, all counters 0, watch_reg 0. Outputs: state_o 0, done_o 0, total_o 0, cycles_o 0, rd_count_o 0.
- IDLE: counters frozen. recv_pulse_i is ignored.
- start_i high at an edge, in any state:
  - per-node, total, cycle and stall counters are set to 0;
  - watch_reg <= watch_i;
  - state <= RUN.
  - recv_pulse_i in that cycle is discarded.
- RUN, each edge without start_i:
  - node_cnt[n] += recv_pulse_i[n], saturating at 2^CNT_WIDTH-1;
  - total += popcount(recv_pulse_i), saturating;
  - cycles += 1;
  - if watch_i !== watch_reg: watch_reg <= watch_i, stall <= 0; else stall += 1.
- RUN exit checks use the post-update values (total_next, cycles_next, stall_next) at the same edge:
  - total_next >= EXPECTED -> COMPLETE;
  - else cycles_next == TEST_TIME -> TIMEOUT;
  - else stall_next == STALL_LIMIT -> STALL.
  - Priority is COMPLETE > TIMEOUT > STALL when several hold on one edge.
- Terminal states (COMPLETE/TIMEOUT/STALL) are sticky: counters frozen, pulses ignored. Exit only via start_i or reset.
- a_rst asserted mid-run: immediate return to reset values, regardless of clk.

## Timing
- A pulse at edge k is visible on total_o/rd_count_o after edge k; latency 1 cycle.
- state_o/done_o are registered. The transition is visible after the same edge whose update met the condition.
- Start at edge s: state_o = 1 after s.
  - With watch_i constant, STALL appears after edge s+STALL_LIMIT, with cycles_o = STALL_LIMIT.
  - With watch_i toggling every cycle, TIMEOUT appears after edge s+TEST_TIME.
- Any watch_i change resets the stall count; the count restarts from 1 on the next unchanged cycle.
- Saturation: no counter wraps. A saturated total still compares >= EXPECTED.
- X/Z on watch_i counts as a change (case inequality). This matches simulation use; synthesis treats it as !=.

## Test plan
- Reset then idle: a_rst=0 for 3 cycles, pulses applied -> all outputs 0, state_o=0; pulses ignored in IDLE.
- Completion, NODES_NUM=4, PACKS_TO_GEN=2, watch toggling:
  - start, then pulse pattern 4'b1111 twice -> state_o=2 one edge after second pattern;
  - total_o=8, rd_count_o=2 for every node;
  - later pulses leave total_o at 8.
- Stall, STALL_LIMIT=5, watch constant:
  - start -> STALL after exactly 5 RUN edges, cycles_o=5;
  - a watch change on RUN cycle 3 delays STALL to cycle 8.
- Timeout, TEST_TIME=20, STALL_LIMIT=100, watch toggling, no pulses -> state_o=3 after 20 edges, cycles_o=20.
- Simultaneous end events, TEST_TIME=6, STALL_LIMIT=6, watch constant, last expected pulse on edge 6 -> state_o=2 (COMPLETE wins).
  - Repeat without the pulse -> state_o=3 (TIMEOUT wins over STALL).
- Restart and saturation:
  - start in STALL -> counters 0, RUN next cycle;
  - with CNT_WIDTH=3, 9 pulses on node 0 -> rd_count_o=7, no wrap;
  - a_rst mid-RUN returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/noc_run_monitor_if.sv
// Run-monitor bus: control/stimulus inputs and status/readback outputs.
// The master drives stimulus; the monitor core is the slave.
interface noc_run_monitor_if #(
    parameter int NODES_NUM   = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int WATCH_WIDTH = 64,
    parameter int IDX_W       = (NODES_NUM > 1) ? $clog2(NODES_NUM) : 1
);
    logic                   start_i;
    logic [NODES_NUM-1:0]   recv_pulse_i;
    logic [WATCH_WIDTH-1:0] watch_i;
    logic [IDX_W-1:0]       rd_node_i;
    logic [2:0]             state_o;
    logic                   done_o;
    logic [CNT_WIDTH-1:0]   total_o;
    logic [CNT_WIDTH-1:0]   cycles_o;
    logic [CNT_WIDTH-1:0]   rd_count_o;

    modport master (
        output start_i, recv_pulse_i, watch_i, rd_node_i,
        input  state_o, done_o, total_o, cycles_o, rd_count_o
    );
    modport slave (
        input  start_i, recv_pulse_i, watch_i, rd_node_i,
        output state_o, done_o, total_o, cycles_o, rd_count_o
    );
endinterface

// File: rtl/noc_run_monitor.sv
// NoC run controller/watchdog: per-node and total packet counters, cycle count,
// activity-bus stall detection and a sticky COMPLETE/TIMEOUT/STALL status.
module noc_run_monitor #(
    parameter int NODES_NUM    = 16,
    parameter int PACKS_TO_GEN = 10,
    parameter int CNT_WIDTH    = 32,
    parameter int WATCH_WIDTH  = 64,
    parameter int STALL_LIMIT  = 10000,
    parameter int TEST_TIME    = 100000,
    parameter int IDX_W        = (NODES_NUM > 1) ? $clog2(NODES_NUM) : 1
) (
    input  logic              clk,
    input  logic              a_rst,
    noc_run_monitor_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_COMPLETE = 3'd2,
        ST_TIMEOUT  = 3'd3,
        ST_STALL    = 3'd4
    } state_t;

    localparam int SUM_W = CNT_WIDTH + $clog2(NODES_NUM + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [63:0] EXPECTED = 64'(PACKS_TO_GEN * NODES_NUM);

    state_t                               state_q, state_d;
    logic [NODES_NUM-1:0][CNT_WIDTH-1:0]  node_cnt_q, node_cnt_d;
    logic [CNT_WIDTH-1:0]                 total_q, total_d;
    logic [CNT_WIDTH-1:0]                 cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]                 stall_q, stall_d;
    logic [WATCH_WIDTH-1:0]               watch_q, watch_d;
    logic [SUM_W-1:0]                     pulse_sum;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= ST_IDLE;
            node_cnt_q <= '0;
            total_q    <= '0;
            cycles_q   <= '0;
            stall_q    <= '0;
            watch_q    <= '0;
        end else begin
            state_q    <= state_d;
            node_cnt_q <= node_cnt_d;
            total_q    <= total_d;
            cycles_q   <= cycles_d;
            stall_q    <= stall_d;
            watch_q    <= watch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        node_cnt_d = node_cnt_q;
        total_d    = total_q;
        cycles_d   = cycles_q;
        stall_d    = stall_q;
        watch_d    = watch_q;
        pulse_sum  = SUM_W'(total_q);
        if (bus.start_i) begin
            // Restart wins over everything; pulses on the start edge are dropped.
            node_cnt_d = '0;
            total_d    = '0;
            cycles_d   = '0;
            stall_d    = '0;
            watch_d    = bus.watch_i;
            state_d    = ST_RUN;
        end else if (state_q == ST_RUN) begin
            for (int n = 0; n < NODES_NUM; n++) begin
                pulse_sum = pulse_sum + SUM_W'(bus.recv_pulse_i[n]);
                if (bus.recv_pulse_i[n])
                    node_cnt_d[n] = sat_inc(node_cnt_q[n]);
            end
            total_d  = (pulse_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pulse_sum[CNT_WIDTH-1:0];
            cycles_d = sat_inc(cycles_q);
            // Case inequality so an X/Z on the bus reads as activity, not a stall.
            if (bus.watch_i !== watch_q) begin
                watch_d = bus.watch_i;
                stall_d = '0;
            end else begin
                stall_d = sat_inc(stall_q);
            end
            if (64'(total_d) >= EXPECTED)
                state_d = ST_COMPLETE;
            else if (64'(cycles_d) == 64'(TEST_TIME))
                state_d = ST_TIMEOUT;
            else if (64'(stall_d) == 64'(STALL_LIMIT))
                state_d = ST_STALL;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.done_o     = (state_q == ST_COMPLETE) || (state_q == ST_TIMEOUT) ||
                            (state_q == ST_STALL);
    assign bus.total_o    = total_q;
    assign bus.cycles_o   = cycles_q;
    assign bus.rd_count_o = (int'(bus.rd_node_i) < NODES_NUM) ? node_cnt_q[bus.rd_node_i] : '0;
endmodule

// File: tb/tb_noc_run_monitor.sv
// Bench for noc_run_monitor: three parameterisations sharing clk/reset,
// expected values queued at stimulus time and popped at observation.
module tb_noc_run_monitor;
    logic clk = 1'b0;
    logic a_rst = 1'b0;
    always #5 clk = ~clk;

    noc_run_monitor_if #(.NODES_NUM(4), .CNT_WIDTH(16), .WATCH_WIDTH(8)) a_if ();
    noc_run_monitor_if #(.NODES_NUM(4), .CNT_WIDTH(16), .WATCH_WIDTH(8)) b_if ();
    noc_run_monitor_if #(.NODES_NUM(3), .CNT_WIDTH(3),  .WATCH_WIDTH(8)) c_if ();

    noc_run_monitor #(.NODES_NUM(4), .PACKS_TO_GEN(2), .CNT_WIDTH(16), .WATCH_WIDTH(8),
                      .STALL_LIMIT(5), .TEST_TIME(20))
        u_a (.clk(clk), .a_rst(a_rst), .bus(a_if.slave));
    noc_run_monitor #(.NODES_NUM(4), .PACKS_TO_GEN(2), .CNT_WIDTH(16), .WATCH_WIDTH(8),
                      .STALL_LIMIT(6), .TEST_TIME(6))
        u_b (.clk(clk), .a_rst(a_rst), .bus(b_if.slave));
    noc_run_monitor #(.NODES_NUM(3), .PACKS_TO_GEN(3), .CNT_WIDTH(3), .WATCH_WIDTH(8),
                      .STALL_LIMIT(100), .TEST_TIME(100))
        u_c (.clk(clk), .a_rst(a_rst), .bus(c_if.slave));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: got %0d expected none queued", obs);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic exp4(input string tag, input int st, input int dn, input int tot, input int cyc);
        push({tag, "_state"}, 32'(st));
        push({tag, "_done"}, 32'(dn));
        push({tag, "_total"}, 32'(tot));
        push({tag, "_cycles"}, 32'(cyc));
    endtask

    task automatic obs_a();
        pop_chk(32'(a_if.state_o)); pop_chk(32'(a_if.done_o));
        pop_chk(32'(a_if.total_o)); pop_chk(32'(a_if.cycles_o));
    endtask
    task automatic obs_b();
        pop_chk(32'(b_if.state_o)); pop_chk(32'(b_if.done_o));
        pop_chk(32'(b_if.total_o)); pop_chk(32'(b_if.cycles_o));
    endtask
    task automatic obs_c();
        pop_chk(32'(c_if.state_o)); pop_chk(32'(c_if.done_o));
        pop_chk(32'(c_if.total_o)); pop_chk(32'(c_if.cycles_o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(); a_if.start_i = 1'b1; tick(); a_if.start_i = 1'b0; endtask
    task automatic start_b(); b_if.start_i = 1'b1; tick(); b_if.start_i = 1'b0; endtask
    task automatic start_c(); c_if.start_i = 1'b1; tick(); c_if.start_i = 1'b0; endtask

    task automatic step_a(input logic [3:0] p, input bit tog);
        a_if.recv_pulse_i = p;
        if (tog) a_if.watch_i = ~a_if.watch_i;
        tick();
        a_if.recv_pulse_i = '0;
    endtask
    task automatic step_b(input logic [3:0] p);
        b_if.recv_pulse_i = p;
        tick();
        b_if.recv_pulse_i = '0;
    endtask
    task automatic step_c(input logic [2:0] p);
        c_if.recv_pulse_i = p;
        c_if.watch_i = ~c_if.watch_i;
        tick();
        c_if.recv_pulse_i = '0;
    endtask

    initial begin
        a_if.start_i = 1'b0; a_if.recv_pulse_i = '0; a_if.watch_i = 8'h5a; a_if.rd_node_i = '0;
        b_if.start_i = 1'b0; b_if.recv_pulse_i = '0; b_if.watch_i = 8'h33; b_if.rd_node_i = '0;
        c_if.start_i = 1'b0; c_if.recv_pulse_i = '0; c_if.watch_i = 8'h00; c_if.rd_node_i = '0;

        // Reset held with pulses present, then IDLE must ignore pulses.
        a_if.recv_pulse_i = 4'hF;
        repeat (3) tick();
        exp4("rst", 0, 0, 0, 0); obs_a();
        push("rst_rd", 0); pop_chk(32'(a_if.rd_count_o));
        a_rst = 1'b1;
        repeat (2) tick();
        exp4("idle", 0, 0, 0, 0); obs_a();
        a_if.recv_pulse_i = '0;

        // Completion with toggling watch.
        start_a();
        exp4("start", 1, 0, 0, 0); obs_a();
        step_a(4'hF, 1'b1);
        exp4("pat1", 1, 0, 4, 1); obs_a();
        step_a(4'hF, 1'b1);
        exp4("cmpl", 2, 1, 8, 2); obs_a();
        for (int n = 0; n < 4; n++) begin
            a_if.rd_node_i = 2'(n);
            #1;
            push($sformatf("cmpl_rd%0d", n), 2); pop_chk(32'(a_if.rd_count_o));
        end
        step_a(4'hF, 1'b1);
        step_a(4'hF, 1'b1);
        exp4("sticky", 2, 1, 8, 2); obs_a();

        // Stall with constant watch.
        start_a();
        repeat (4) step_a(4'h0, 1'b0);
        exp4("stl4", 1, 0, 0, 4); obs_a();
        step_a(4'h0, 1'b0);
        exp4("stall", 4, 1, 0, 5); obs_a();

        // Restart from STALL, watch change on RUN cycle 3 delays stall to 8.
        start_a();
        exp4("rstrt", 1, 0, 0, 0); obs_a();
        repeat (2) step_a(4'h0, 1'b0);
        step_a(4'h0, 1'b1);
        repeat (4) step_a(4'h0, 1'b0);
        exp4("stl7", 1, 0, 0, 7); obs_a();
        step_a(4'h0, 1'b0);
        exp4("stl8", 4, 1, 0, 8); obs_a();

        // Timeout with toggling watch and no pulses.
        start_a();
        repeat (19) step_a(4'h0, 1'b1);
        exp4("to19", 1, 0, 0, 19); obs_a();
        step_a(4'h0, 1'b1);
        exp4("tmo", 3, 1, 0, 20); obs_a();

        // Asynchronous reset mid-run, asserted between clock edges.
        a_if.rd_node_i = 2'd0;
        start_a();
        repeat (3) step_a(4'h1, 1'b1);
        exp4("pre_arst", 1, 0, 3, 3); obs_a();
        push("pre_arst_rd", 3); pop_chk(32'(a_if.rd_count_o));
        #2 a_rst = 1'b0;
        #1;
        exp4("arst", 0, 0, 0, 0); obs_a();
        push("arst_rd", 0); pop_chk(32'(a_if.rd_count_o));
        tick();
        a_rst = 1'b1;
        tick();

        // Simultaneous end events: COMPLETE beats TIMEOUT and STALL.
        start_b();
        step_b(4'hF);
        step_b(4'h7);
        repeat (3) step_b(4'h0);
        exp4("sim5", 1, 0, 7, 5); obs_b();
        step_b(4'h1);
        exp4("sim_cmpl", 2, 1, 8, 6); obs_b();
        // Same run without the last pulse: TIMEOUT beats STALL.
        start_b();
        step_b(4'hF);
        step_b(4'h7);
        repeat (4) step_b(4'h0);
        exp4("sim_tmo", 3, 1, 7, 6); obs_b();

        // Saturation of 3-bit counters.
        start_c();
        repeat (9) step_c(3'b001);
        exp4("sat", 1, 0, 7, 7); obs_c();
        c_if.rd_node_i = 2'd0; #1;
        push("sat_rd0", 7); pop_chk(32'(c_if.rd_count_o));
        c_if.rd_node_i = 2'd1; #1;
        push("sat_rd1", 0); pop_chk(32'(c_if.rd_count_o));
        c_if.rd_node_i = 2'd3; #1;
        push("sat_rd_oob", 0); pop_chk(32'(c_if.rd_count_o));

        if (sbq.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
